frame_addr_gen: RTL and testbench



---
 rtl/frame_addr_gen.sv | 129 ++++++++++++
 tb/tb_frame_addr_gen.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_addr_gen.sv
// frame_addr_gen: frame-buffer write-address generator for the camera capture path.
// It counts qualified pixels between active-low vsync pulses and tracks the input
// column and row. Every DECIM-th pixel on every DECIM-th line is kept. Each kept
// pixel produces a registered linear address with a one-cycle write strobe.
// Optional feature: define FRAME_ADDR_GEN_MIRROR_EN to write each output line
// right-to-left (horizontal mirror). Without it, no mirror logic is built.
module frame_addr_gen #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int DECIM    = 1,
    parameter int ADDR_W   = 17
) (
    input  logic              CLK25,
    input  logic              reset,
    input  logic              enable,
    input  logic              vsync,
    output logic [ADDR_W-1:0] address,
    output logic              wr_en,
    output logic              frame_done,
    output logic              overflow,
    output logic              busy
);

    localparam int OUT_W = H_ACTIVE / DECIM;
    localparam int OUT_H = V_ACTIVE / DECIM;
    localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int OXW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [XW-1:0]     X_LAST        = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]     Y_LAST        = YW'(V_ACTIVE - 1);
    // DECIM is 1, 2 or 4, so "coordinate mod DECIM == 0" is a low-bit mask test.
    localparam logic [XW-1:0]     X_MASK        = XW'(DECIM - 1);
    localparam logic [YW-1:0]     Y_MASK        = YW'(DECIM - 1);
    localparam logic [OXW-1:0]    OX_LAST       = OXW'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP      = ADDR_W'(OUT_W);
    // The last output pixel is the last column of the row that starts here.
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((OUT_H - 1) * OUT_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAME,
        ST_DONE
    } state_t;

    state_t            state_reg;
    logic [XW-1:0]     x_reg;
    logic [YW-1:0]     y_reg;
    logic [OXW-1:0]    ox_reg;
    logic [ADDR_W-1:0] row_base_reg;

    logic              kept;
    logic              last_out;
    logic [ADDR_W-1:0] kept_addr;

    // Decode whether the current input pixel survives decimation, whether it is
    // the final output pixel, and where it lands in the frame buffer.
    always_comb begin
        kept      = ((x_reg & X_MASK) == '0) && ((y_reg & Y_MASK) == '0);
        last_out  = (ox_reg == OX_LAST) && (row_base_reg == LAST_ROW_BASE);
`ifdef FRAME_ADDR_GEN_MIRROR_EN
        kept_addr = row_base_reg + (ADDR_W'(OUT_W - 1) - ADDR_W'(ox_reg));
`else
        kept_addr = row_base_reg + ADDR_W'(ox_reg);
`endif
    end

    // Frame FSM with counters and registered outputs; vsync low restarts the
    // frame from any state and always suppresses the write in that cycle.
    always_ff @(posedge CLK25 or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            x_reg        <= '0;
            y_reg        <= '0;
            ox_reg       <= '0;
            row_base_reg <= '0;
            address      <= '0;
            wr_en        <= 1'b0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (!vsync) begin
                x_reg        <= '0;
                y_reg        <= '0;
                ox_reg       <= '0;
                row_base_reg <= '0;
                overflow     <= 1'b0;
                state_reg    <= ST_FRAME;
                busy         <= 1'b1;
            end else if (enable) begin
                case (state_reg)
                    ST_FRAME: begin
                        if (x_reg == X_LAST) begin
                            x_reg <= '0;
                            y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
                        end else begin
                            x_reg <= x_reg + 1'b1;
                        end
                        if (kept) begin
                            address <= kept_addr;
                            wr_en   <= 1'b1;
                            if (ox_reg == OX_LAST) begin
                                ox_reg       <= '0;
                                row_base_reg <= row_base_reg + ROW_STEP;
                            end else begin
                                ox_reg <= ox_reg + 1'b1;
                            end
                            if (last_out) begin
                                frame_done <= 1'b1;
                                state_reg  <= ST_DONE;
                                busy       <= 1'b0;
                            end
                        end
                    end
                    ST_DONE: begin
                        overflow <= 1'b1;
                    end
                    default: begin
                        // IDLE: pixels are ignored until a vsync low is seen.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_addr_gen.sv
// Testbench for frame_addr_gen. Three instances with a reduced 16x12 geometry
// (DECIM 1, 2 and 4) share one stimulus stream; a pixel-count reference model
// derives every expected output from the frame rules with plain arithmetic.
module tb_frame_addr_gen;

    localparam int NI = 3;
    localparam int PH = 16;
    localparam int PV = 12;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b0;
    logic vsync  = 1'b1;

    logic [7:0]  a0;
    logic [5:0]  a1;
    logic [3:0]  a2;
    logic [16:0] d_addr [NI];
    logic        d_wr   [NI];
    logic        d_fd   [NI];
    logic        d_ov   [NI];
    logic        d_busy [NI];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    frame_addr_gen #(.H_ACTIVE(PH), .V_ACTIVE(PV), .DECIM(1), .ADDR_W(8)) u_d1 (
        .CLK25(clk), .reset(reset), .enable(enable), .vsync(vsync), .address(a0),
        .wr_en(d_wr[0]), .frame_done(d_fd[0]), .overflow(d_ov[0]), .busy(d_busy[0]));
    frame_addr_gen #(.H_ACTIVE(PH), .V_ACTIVE(PV), .DECIM(2), .ADDR_W(6)) u_d2 (
        .CLK25(clk), .reset(reset), .enable(enable), .vsync(vsync), .address(a1),
        .wr_en(d_wr[1]), .frame_done(d_fd[1]), .overflow(d_ov[1]), .busy(d_busy[1]));
    frame_addr_gen #(.H_ACTIVE(PH), .V_ACTIVE(PV), .DECIM(4), .ADDR_W(4)) u_d4 (
        .CLK25(clk), .reset(reset), .enable(enable), .vsync(vsync), .address(a2),
        .wr_en(d_wr[2]), .frame_done(d_fd[2]), .overflow(d_ov[2]), .busy(d_busy[2]));

    assign d_addr[0] = {9'd0, a0};
    assign d_addr[1] = {11'd0, a1};
    assign d_addr[2] = {13'd0, a2};

    // ---------------- reference model (pixel-count based) ----------------
    function automatic int dec_of(int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction
    function automatic int ow(int i);
        return PH / dec_of(i);
    endfunction
    function automatic int oh(int i);
        return PV / dec_of(i);
    endfunction
    function automatic int last_idx(int i);
        return ow(i) * oh(i) - 1;
    endfunction
    // n = number of pixels accepted before this one in the current frame
    function automatic bit is_kept(int i, int n);
        return ((n % PH) % dec_of(i) == 0) && ((n / PH) % dec_of(i) == 0);
    endfunction
    function automatic int out_idx(int i, int n);
        return ((n / PH) / dec_of(i)) * ow(i) + (n % PH) / dec_of(i);
    endfunction
    // address of the k-th kept pixel of a frame (k counts from 0)
    function automatic int kth_addr(int i, int k);
`ifdef FRAME_ADDR_GEN_MIRROR_EN
        return (k / ow(i)) * ow(i) + (ow(i) - 1 - (k % ow(i)));
`else
        return k;
`endif
    endfunction

    int          m_n    [NI];
    int          m_st   [NI];   // 0 = idle, 1 = frame, 2 = done
    logic [16:0] e_addr [NI];
    logic        e_wr   [NI];
    logic        e_fd   [NI];
    logic        e_ov   [NI];
    logic        e_busy [NI];

    // Expected outputs one edge after the sampled inputs.
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_n[i] <= 0; m_st[i] <= 0; e_addr[i] <= '0;
                e_wr[i] <= 1'b0; e_fd[i] <= 1'b0; e_ov[i] <= 1'b0; e_busy[i] <= 1'b0;
            end else begin
                e_wr[i] <= 1'b0;
                e_fd[i] <= 1'b0;
                if (!vsync) begin
                    m_n[i] <= 0; m_st[i] <= 1; e_ov[i] <= 1'b0; e_busy[i] <= 1'b1;
                end else if (enable && m_st[i] == 1) begin
                    m_n[i] <= m_n[i] + 1;
                    if (is_kept(i, m_n[i])) begin
                        e_addr[i] <= 17'(kth_addr(i, out_idx(i, m_n[i])));
                        e_wr[i]   <= 1'b1;
                        if (out_idx(i, m_n[i]) == last_idx(i)) begin
                            e_fd[i] <= 1'b1; m_st[i] <= 2; e_busy[i] <= 1'b0;
                        end
                    end
                end else if (enable && m_st[i] == 2) begin
                    e_ov[i] <= 1'b1;
                end
            end
        end
    end

    // Drive one cycle of inputs at a falling edge; return at the next falling edge.
    task automatic cyc(input logic en, input logic vs);
        enable = en;
        vsync  = vs;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; vsync = 1'b1;
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (d_addr[i] !== 17'd0 || d_wr[i] !== 1'b0 || d_fd[i] !== 1'b0 || d_ov[i] !== 1'b0 || d_busy[i] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_state dut%0d: got addr=%0d wr=%b fd=%b ov=%b busy=%b, want all zero",
                         i, d_addr[i], d_wr[i], d_fd[i], d_ov[i], d_busy[i]);
            end
        end
        reset = 1'b0;
        // Without a vsync low the block stays idle and ignores pixels.
        for (int c = 0; c < 10; c++) begin
            cyc(1'b1, 1'b1);
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (d_wr[i] !== 1'b0 || d_busy[i] !== 1'b0 || d_ov[i] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL idle_ignore dut%0d c=%0d: got wr=%b busy=%b ov=%b, want 0 0 0",
                             i, c, d_wr[i], d_busy[i], d_ov[i]);
                end
            end
        end
        $display("test_reset: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_full_frame();
        int          wr_cnt [NI];
        int          fd_cnt [NI];
        logic [16:0] fd_a   [NI];
        for (int i = 0; i < NI; i++) begin wr_cnt[i] = 0; fd_cnt[i] = 0; fd_a[i] = '0; end
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        for (int c = 0; c < PH * PV; c++) begin
            cyc(1'b1, 1'b1);
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (d_addr[i] !== e_addr[i] || d_wr[i] !== e_wr[i] || d_fd[i] !== e_fd[i] || d_ov[i] !== e_ov[i] || d_busy[i] !== e_busy[i]) begin
                    n_errors++;
                    $display("FAIL full_frame dut%0d c=%0d: got addr=%0d wr=%b fd=%b ov=%b busy=%b, want addr=%0d wr=%b fd=%b ov=%b busy=%b",
                             i, c, d_addr[i], d_wr[i], d_fd[i], d_ov[i], d_busy[i], e_addr[i], e_wr[i], e_fd[i], e_ov[i], e_busy[i]);
                end
                if (d_wr[i] === 1'b1) wr_cnt[i]++;
                if (d_fd[i] === 1'b1) begin fd_cnt[i]++; fd_a[i] = d_addr[i]; end
            end
        end
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (wr_cnt[i] != ow(i) * oh(i) || fd_cnt[i] != 1 || fd_a[i] != 17'(kth_addr(i, last_idx(i))) || d_busy[i] !== 1'b0) begin
                n_errors++;
                $display("FAIL frame_totals dut%0d: got writes=%0d done_pulses=%0d done_addr=%0d busy=%b, want %0d 1 %0d 0",
                         i, wr_cnt[i], fd_cnt[i], fd_a[i], d_busy[i], ow(i) * oh(i), kth_addr(i, last_idx(i)));
            end
        end
        // Undecimated frame ends exactly on the last input pixel: no overrun yet.
        n_checks++;
        if (d_ov[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL no_overrun dut0: got overflow=%b, want 0", d_ov[0]);
        end
        $display("test_full_frame: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_overrun();
        for (int c = 0; c < 5; c++) begin
            cyc(1'b1, 1'b1);
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (d_ov[i] !== 1'b1 || d_wr[i] !== 1'b0 || d_addr[i] !== 17'(kth_addr(i, last_idx(i)))) begin
                    n_errors++;
                    $display("FAIL overrun dut%0d c=%0d: got ov=%b wr=%b addr=%0d, want 1 0 %0d",
                             i, c, d_ov[i], d_wr[i], d_addr[i], kth_addr(i, last_idx(i)));
                end
            end
        end
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (d_ov[i] !== 1'b0 || d_wr[i] !== 1'b1 || d_addr[i] !== 17'(kth_addr(i, 0))) begin
                n_errors++;
                $display("FAIL overrun_clear dut%0d: got ov=%b wr=%b addr=%0d, want 0 1 %0d",
                         i, d_ov[i], d_wr[i], d_addr[i], kth_addr(i, 0));
            end
        end
        $display("test_overrun: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_mid_vsync();
        for (int c = 0; c < 100; c++) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (d_wr[i] !== 1'b1 || d_addr[i] !== 17'(kth_addr(i, 0)) || d_busy[i] !== 1'b1) begin
                n_errors++;
                $display("FAIL mid_vsync dut%0d: got wr=%b addr=%0d busy=%b, want 1 %0d 1",
                         i, d_wr[i], d_addr[i], d_busy[i], kth_addr(i, 0));
            end
        end
        $display("test_mid_vsync: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 50; c++) cyc(1'b1, 1'b1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (d_addr[i] !== 17'd0 || d_wr[i] !== 1'b0 || d_fd[i] !== 1'b0 || d_ov[i] !== 1'b0 || d_busy[i] !== 1'b0) begin
                n_errors++;
                $display("FAIL async_reset dut%0d: got addr=%0d wr=%b fd=%b ov=%b busy=%b, want all zero",
                         i, d_addr[i], d_wr[i], d_fd[i], d_ov[i], d_busy[i]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            cyc(1'b1, 1'b1);
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (d_wr[i] !== 1'b0 || d_busy[i] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL reset_no_write dut%0d c=%0d: got wr=%b busy=%b, want 0 0", i, c, d_wr[i], d_busy[i]);
                end
            end
        end
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (d_wr[i] !== 1'b1 || d_addr[i] !== 17'(kth_addr(i, 0))) begin
                n_errors++;
                $display("FAIL reset_resume dut%0d: got wr=%b addr=%0d, want 1 %0d", i, d_wr[i], d_addr[i], kth_addr(i, 0));
            end
        end
        $display("test_mid_reset: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_stall();
        int wr_cnt [NI];
        for (int i = 0; i < NI; i++) wr_cnt[i] = 0;
        cyc(1'b0, 1'b0);
        for (int c = 0; c < 2 * PH * PV; c++) begin
            cyc((c % 2) == 0, 1'b1);
            for (int i = 0; i < NI; i++) begin
                if (d_wr[i] === 1'b1) begin
                    n_checks++;
                    if (d_addr[i] !== 17'(kth_addr(i, wr_cnt[i]))) begin
                        n_errors++;
                        $display("FAIL stall_order dut%0d write#%0d: got addr=%0d, want %0d",
                                 i, wr_cnt[i], d_addr[i], kth_addr(i, wr_cnt[i]));
                    end
                    wr_cnt[i]++;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (wr_cnt[i] != ow(i) * oh(i)) begin
                n_errors++;
                $display("FAIL stall_count dut%0d: got writes=%0d, want %0d", i, wr_cnt[i], ow(i) * oh(i));
            end
        end
        $display("test_stall: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_collision();
        cyc(1'b0, 1'b0);
        for (int c = 0; c < 20; c++) cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (d_wr[i] !== 1'b0 || d_busy[i] !== 1'b1) begin
                n_errors++;
                $display("FAIL collision_drop dut%0d: got wr=%b busy=%b, want 0 1", i, d_wr[i], d_busy[i]);
            end
        end
        cyc(1'b1, 1'b1);
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (d_wr[i] !== 1'b1 || d_addr[i] !== 17'(kth_addr(i, 0))) begin
                n_errors++;
                $display("FAIL collision_next dut%0d: got wr=%b addr=%0d, want 1 %0d", i, d_wr[i], d_addr[i], kth_addr(i, 0));
            end
        end
        $display("test_collision: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0);
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (d_addr[i] !== e_addr[i] || d_wr[i] !== e_wr[i] || d_fd[i] !== e_fd[i] || d_ov[i] !== e_ov[i] || d_busy[i] !== e_busy[i]) begin
                    n_errors++;
                    $display("FAIL random dut%0d c=%0d: got addr=%0d wr=%b fd=%b ov=%b busy=%b, want addr=%0d wr=%b fd=%b ov=%b busy=%b",
                             i, c, d_addr[i], d_wr[i], d_fd[i], d_ov[i], d_busy[i], e_addr[i], e_wr[i], e_fd[i], e_ov[i], e_busy[i]);
                end
            end
        end
        $display("test_random: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_overrun();
        test_mid_vsync();
        test_mid_reset();
        test_stall();
        test_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
